// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: tracks BCD score, balls remaining and the
// NEWGAME/PLAY/NEWBALL/OVER sequence, with registered display/graphics enables.
module pong_game_ctrl #(
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic       graph_still,
  output logic [3:0] text_en
);

  localparam int TW = (TIMER_TICKS > 0) ? $clog2(TIMER_TICKS + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_TICKS);

  typedef enum logic [1:0] {
    S_NEWGAME,
    S_PLAY,
    S_NEWBALL,
    S_OVER
  } state_t;

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [1:0]    r_ball, w_ball_next;
  logic [3:0]    r_dig0, w_dig0_next;
  logic [3:0]    r_dig1, w_dig1_next;
  logic          r_graph_still, w_graph_still_next;
  logic [3:0]    r_text_en, w_text_en_next;
  logic          w_timer_done;
  logic          w_btn_any;

  assign w_timer_done = (r_timer == '0);
  assign w_btn_any    = (btn != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_NEWGAME;
      r_timer       <= '0;
      r_ball        <= 2'd3;
      r_dig0        <= '0;
      r_dig1        <= '0;
      r_graph_still <= 1'b1;
      r_text_en     <= 4'b1110;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_ball        <= w_ball_next;
      r_dig0        <= w_dig0_next;
      r_dig1        <= w_dig1_next;
      r_graph_still <= w_graph_still_next;
      r_text_en     <= w_text_en_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ball_next  = r_ball;
    w_dig0_next  = r_dig0;
    w_dig1_next  = r_dig1;
    w_timer_next = r_timer;
    if (refresh_tick && !w_timer_done)
      w_timer_next = r_timer - 1'b1;

    unique case (r_state)
      S_NEWGAME: begin
        if (w_btn_any) begin
          w_state_next = S_PLAY;
          w_ball_next  = 2'd2;
        end
      end
      S_PLAY: begin
        // miss dominates a coincident hit
        if (miss) begin
          w_timer_next = TIMER_LOAD;
          if (r_ball == '0) begin
            w_state_next = S_OVER;
          end else begin
            w_state_next = S_NEWBALL;
            w_ball_next  = r_ball - 1'b1;
          end
        end else if (hit) begin
          if (r_dig0 == 4'd9) begin
            w_dig0_next = '0;
            w_dig1_next = (r_dig1 == 4'd9) ? '0 : r_dig1 + 1'b1;
          end else begin
            w_dig0_next = r_dig0 + 1'b1;
          end
        end
      end
      S_NEWBALL: begin
        if (w_timer_done && w_btn_any)
          w_state_next = S_PLAY;
      end
      S_OVER: begin
        if (w_timer_done) begin
          w_state_next = S_NEWGAME;
          w_ball_next  = 2'd3;
          w_dig0_next  = '0;
          w_dig1_next  = '0;
        end
      end
      default: w_state_next = S_NEWGAME;
    endcase
  end

  // Enables are decoded from the next state so they register alongside it.
  always_comb begin
    w_graph_still_next = (w_state_next != S_PLAY);
    w_text_en_next     = 4'b1110;
    unique case (w_state_next)
      S_NEWGAME: w_text_en_next = 4'b1110;
      S_PLAY:    w_text_en_next = 4'b1100;
      S_NEWBALL: w_text_en_next = 4'b1100;
      S_OVER:    w_text_en_next = 4'b1101;
      default:   w_text_en_next = 4'b1110;
    endcase
  end

  assign dig0        = r_dig0;
  assign dig1        = r_dig1;
  assign ball        = r_ball;
  assign graph_still = r_graph_still;
  assign text_en     = r_text_en;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, a 99->00 wrap sequence,
// then random stimulus checked against a score/ball/mode reference model.
module tb_pong_game_ctrl;

  localparam int unsigned T = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refresh_tick = 1'b0;
  logic [1:0] btn = '0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] dig0, dig1;
  logic [1:0] ball;
  logic       graph_still;
  logic [3:0] text_en;

  pong_game_ctrl #(.TIMER_TICKS(T)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn),
    .hit(hit), .miss(miss), .dig0(dig0), .dig1(dig1), .ball(ball),
    .graph_still(graph_still), .text_en(text_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: game mode, balls, score as a plain integer, timer count.
  localparam int M_NG = 0, M_PLAY = 1, M_NB = 2, M_OVER = 3;
  int m_mode, m_ball, m_score, m_timer;

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic       hit, miss, tick;
    int         score;
    int         ball;
    logic       gs;
    logic [3:0] ten;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic r, logic [1:0] b, logic h, logic m, logic t,
                              int sc, int bl, logic gs, logic [3:0] ten);
    vec_t v;
    v.rst = r; v.btn = b; v.hit = h; v.miss = m; v.tick = t;
    v.score = sc; v.ball = bl; v.gs = gs; v.ten = ten;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(logic r, logic [1:0] b, logic h, logic m, logic t);
    int t_old;
    if (r) begin
      m_mode = M_NG; m_ball = 3; m_score = 0; m_timer = 0;
      return;
    end
    t_old = m_timer;
    if (t && m_timer > 0) m_timer = m_timer - 1;
    case (m_mode)
      M_NG: if (b != 0) begin m_mode = M_PLAY; m_ball = 2; end
      M_PLAY: begin
        if (m) begin
          m_timer = T;
          if (m_ball == 0) m_mode = M_OVER;
          else begin m_ball = m_ball - 1; m_mode = M_NB; end
        end else if (h) m_score = (m_score + 1) % 100;
      end
      M_NB: if (t_old == 0 && b != 0) m_mode = M_PLAY;
      default: if (t_old == 0) begin m_mode = M_NG; m_ball = 3; m_score = 0; end
    endcase
  endtask

  task automatic step(logic r, logic [1:0] b, logic h, logic m, logic t);
    reset = r; btn = b; hit = h; miss = m; refresh_tick = t;
    @(posedge clk);
    model_update(r, b, h, m, t);
    #1;
  endtask

  task automatic check_outputs(string tag, int sc, int bl, logic gs, logic [3:0] ten);
    check({tag, ".dig1"}, int'(dig1), sc / 10);
    check({tag, ".dig0"}, int'(dig0), sc % 10);
    check({tag, ".ball"}, int'(ball), bl);
    check({tag, ".graph_still"}, int'(graph_still), int'(gs));
    check({tag, ".text_en"}, int'(text_en), int'(ten));
  endtask

  function automatic logic [3:0] model_ten();
    case (m_mode)
      M_NG:    return 4'b1110;
      M_OVER:  return 4'b1101;
      default: return 4'b1100;
    endcase
  endfunction

  localparam logic [3:0] NG = 4'b1110, PL = 4'b1100, NB = 4'b1100, OV = 4'b1101;

  initial begin
    // reset, then hit/miss ignored in NEWGAME
    add(1, 0, 0, 0, 0, 0, 3, 1, NG);
    add(0, 0, 1, 1, 1, 0, 3, 1, NG);
    add(0, 1, 0, 0, 0, 0, 2, 0, PL);
    for (int i = 1; i <= 10; i++) add(0, 0, 1, 0, 0, i, 2, 0, PL);
    // hit+miss together: miss wins
    add(0, 0, 1, 1, 0, 10, 1, 1, NB);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 10, 1, 1, NB);
    add(0, 1, 0, 0, 0, 10, 1, 0, PL);
    add(0, 0, 0, 1, 0, 10, 0, 1, NB);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 10, 0, 1, NB);
    add(0, 0, 1, 0, 0, 10, 0, 1, NB);
    add(0, 2, 0, 0, 0, 10, 0, 0, PL);
    add(0, 0, 1, 0, 0, 11, 0, 0, PL);
    add(0, 0, 0, 1, 0, 11, 0, 1, OV);
    add(0, 1, 1, 0, 1, 11, 0, 1, OV);
    add(0, 0, 0, 0, 1, 11, 0, 1, OV);
    // reset mid-OVER beats all inputs; later ticks change nothing
    add(1, 1, 1, 1, 1, 0, 3, 1, NG);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 3, 1, NG);
    // full game to OVER, then timeout back to NEWGAME
    add(0, 3, 0, 0, 0, 0, 2, 0, PL);
    add(0, 0, 0, 1, 0, 0, 1, 1, NB);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 1, 1, NB);
    add(0, 1, 0, 0, 0, 0, 1, 0, PL);
    add(0, 0, 0, 1, 0, 0, 0, 1, NB);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 1, NB);
    add(0, 1, 0, 0, 0, 0, 0, 0, PL);
    add(0, 0, 1, 0, 0, 1, 0, 0, PL);
    add(0, 0, 1, 0, 0, 2, 0, 0, PL);
    add(0, 0, 0, 1, 0, 2, 0, 1, OV);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 2, 0, 1, OV);
    add(0, 0, 0, 0, 0, 0, 3, 1, NG);

    m_mode = M_NG; m_ball = 3; m_score = 0; m_timer = 0;
    @(negedge clk);
    foreach (vecs[i])
      begin
        step(vecs[i].rst, vecs[i].btn, vecs[i].hit, vecs[i].miss, vecs[i].tick);
        check_outputs($sformatf("vec%0d", i), vecs[i].score, vecs[i].ball,
                      vecs[i].gs, vecs[i].ten);
      end

    // 99 -> 00 wrap
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 99; i++) step(0, 0, 1, 0, 0);
    check("wrap.pre.dig1", int'(dig1), 9);
    check("wrap.pre.dig0", int'(dig0), 9);
    step(0, 0, 1, 0, 0);
    check("wrap.post.dig1", int'(dig1), 0);
    check("wrap.post.dig0", int'(dig0), 0);
    check("wrap.post.ball", int'(ball), 2);

    // random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      logic       r, h, m, t;
      logic [1:0] b;
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      h = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 2) == 0);
      step(r, b, h, m, t);
      check_outputs("rand", m_score, m_ball, (m_mode != M_PLAY), model_ten());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
